// File: rtl/slow_clk_pkg.sv
// rtl/slow_clk_pkg.sv - shared state encoding and default sizing for the slow clock blocks
package slow_clk_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACQ    = 3'd1,
    MEAS   = 3'd2,
    LOCKED = 3'd3,
    LOST   = 3'd4
  } clk_state_t;

  localparam int default_counter_size = 17;
  localparam logic [default_counter_size-1:0] default_timeout_limit = 17'h1FFFF;

  // States in which a missing edge counts toward the loss timeout
  function automatic logic is_tracking(input clk_state_t s);
    return (s == ACQ) || (s == MEAS) || (s == LOCKED);
  endfunction

endpackage

// File: rtl/slow_clk_monitor_if.sv
// rtl/slow_clk_monitor_if.sv - slow clock input and status/measurement outputs of the monitor
interface slow_clk_monitor_if
  import slow_clk_pkg::*;
#(
  parameter int counter_size = default_counter_size
);
  logic                    slow_clk_in;
  logic                    rise_tick;
  logic                    fall_tick;
  logic [counter_size-1:0] half_period;
  logic                    period_valid;
  logic                    locked;
  logic                    lost;

  modport master (
    output slow_clk_in,
    input  rise_tick, fall_tick, half_period, period_valid, locked, lost
  );

  modport slave (
    input  slow_clk_in,
    output rise_tick, fall_tick, half_period, period_valid, locked, lost
  );
endinterface

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchronizer with edge detect and registered rise/fall ticks
module sync_edge_detect (
  input  logic fast_clk,
  input  logic reset,
  input  logic slow_clk_in,
  output logic edge_now,
  output logic rise_tick,
  output logic fall_tick
);
  logic sync1;
  logic sync2;
  logic prev;

  assign edge_now = sync2 ^ prev;

  // prev resets low, so an input already high at release yields one rise
  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      prev      <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      sync1     <= slow_clk_in;
      sync2     <= sync1;
      prev      <= sync2;
      rise_tick <= edge_now & sync2;
      fall_tick <= edge_now & ~sync2;
    end
  end
endmodule

// File: rtl/slow_clk_monitor.sv
// rtl/slow_clk_monitor.sv - measures slow clock half-periods in fast_clk cycles and tracks lock/loss
module slow_clk_monitor
  import slow_clk_pkg::*;
#(
  parameter int                      counter_size  = default_counter_size,
  parameter logic [counter_size-1:0] timeout_limit = default_timeout_limit,
  parameter int                      tolerance     = 2,
  parameter int                      lock_edges    = 4
) (
  input  logic               fast_clk,
  input  logic               reset,
  slow_clk_monitor_if.slave  bus
);
  localparam int lc_w = $clog2(lock_edges + 1);
  localparam logic [counter_size:0] tol_w       = (counter_size + 1)'(tolerance);
  localparam logic [lc_w-1:0]       lock_target = lc_w'(lock_edges);

  clk_state_t              state;
  clk_state_t              state_next;
  logic [counter_size-1:0] counter;
  logic [counter_size:0]   ref_val;
  logic [lc_w-1:0]         lock_count;
  logic [lc_w-1:0]         lc_next;
  logic [counter_size-1:0] half_period_q;
  logic                    period_valid_q;

  logic                    edge_now;
  logic [counter_size:0]   cap;
  logic [counter_size:0]   diff;
  logic                    match;
  logic                    timeout;
  logic                    capture;

  sync_edge_detect u_sync (
    .fast_clk    (fast_clk),
    .reset       (reset),
    .slow_clk_in (bus.slow_clk_in),
    .edge_now    (edge_now),
    .rise_tick   (bus.rise_tick),
    .fall_tick   (bus.fall_tick)
  );

  // One extra bit so a saturated counter plus one and the difference never wrap
  assign cap     = {1'b0, counter} + 1'b1;
  assign diff    = (cap >= ref_val) ? (cap - ref_val) : (ref_val - cap);
  assign match   = (diff <= tol_w);
  assign timeout = (counter == timeout_limit) && !edge_now;
  assign capture = edge_now && is_tracking(state);

  always_comb begin
    state_next = state;
    lc_next    = lock_count;
    case (state)
      IDLE: begin
        if (edge_now) state_next = ACQ;
      end
      ACQ: begin
        if (edge_now) begin
          lc_next    = '0;
          state_next = MEAS;
        end
      end
      MEAS: begin
        if (edge_now) begin
          if (match) begin
            lc_next = lock_count + 1'b1;
            if (lc_next == lock_target) state_next = LOCKED;
          end else begin
            lc_next = '0;
          end
        end
      end
      LOCKED: begin
        if (edge_now && !match) begin
          lc_next    = '0;
          state_next = MEAS;
        end
      end
      LOST: begin
        if (edge_now) state_next = ACQ;
      end
      default: begin
        state_next = IDLE;
        lc_next    = '0;
      end
    endcase
    // timeout already excludes an edge in the same cycle, so the edge wins
    if (timeout && is_tracking(state)) begin
      state_next = LOST;
      lc_next    = '0;
    end
  end

  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      lock_count     <= '0;
      counter        <= '0;
      ref_val        <= '0;
      half_period_q  <= '0;
      period_valid_q <= 1'b0;
    end else begin
      state          <= state_next;
      lock_count     <= lc_next;
      period_valid_q <= capture;
      if (edge_now) begin
        counter <= '0;
      end else if (counter != timeout_limit) begin
        counter <= counter + 1'b1;
      end
      if (capture) begin
        half_period_q <= cap[counter_size-1:0];
        ref_val       <= cap;
      end
    end
  end

  assign bus.half_period  = half_period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.locked       = (state == LOCKED);
  assign bus.lost         = (state == LOST);
endmodule

// File: tb/tb_slow_clk_monitor.sv
// tb/tb_slow_clk_monitor.sv - directed and randomized bench for slow_clk_monitor
module tb_slow_clk_monitor;
  localparam int LIMIT = 100;
  localparam int TOL   = 2;
  localparam int LOCKN = 4;
  localparam int S_IDLE = 0, S_ACQ = 1, S_MEAS = 2, S_LOCKED = 3, S_LOST = 4;

  logic fast_clk = 1'b0;
  logic reset    = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  slow_clk_monitor_if #(.counter_size(17)) bus ();

  slow_clk_monitor #(
    .counter_size  (17),
    .timeout_limit (17'd100),
    .tolerance     (TOL),
    .lock_edges    (LOCKN)
  ) dut (
    .fast_clk (fast_clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 fast_clk = ~fast_clk;

  // Reference model: edges appear three samples after the input changes
  bit smp[$];
  int n, last, st, refv, lc, m_hp;
  bit m_rt, m_ft, m_pv;

  function automatic bit s_at(input int i);
    if (i < 0) return 1'b0;
    return smp[i];
  endfunction

  task automatic model_reset();
    smp.delete();
    n = 0; last = -1; st = S_IDLE; refv = 0; lc = 0; m_hp = 0;
    m_rt = 0; m_ft = 0; m_pv = 0;
  endtask

  task automatic model_step(input bit s);
    int cnt, cap, d;
    bit e, lvl;
    smp.push_back(s);
    lvl  = s_at(n - 2);
    e    = (lvl != s_at(n - 3));
    m_rt = e && lvl;
    m_ft = e && !lvl;
    m_pv = 0;
    cnt  = n - last - 1;
    if (cnt > LIMIT) cnt = LIMIT;
    if (e) begin
      cap  = cnt + 1;
      last = n;
      if (st == S_IDLE || st == S_LOST) begin
        st = S_ACQ;
      end else begin
        m_pv = 1; m_hp = cap;
        if (st == S_ACQ) begin
          lc = 0; st = S_MEAS;
        end else begin
          d = cap - refv;
          if (d < 0) d = -d;
          if (d <= TOL) begin
            if (st == S_MEAS) begin
              lc++;
              if (lc == LOCKN) st = S_LOCKED;
            end
          end else begin
            lc = 0; st = S_MEAS;
          end
        end
        refv = cap;
      end
    end else if (cnt == LIMIT && (st == S_ACQ || st == S_MEAS || st == S_LOCKED)) begin
      st = S_LOST; lc = 0;
    end
    n++;
  endtask

  initial begin
    logic [21:0] exp_v, act_v;
    model_reset();
    forever begin
      @(posedge fast_clk);
      if (reset) begin
        model_reset();
      end else begin
        model_step(bus.slow_clk_in);
        #1;
        exp_v = {m_rt, m_ft, m_pv, (st == S_LOCKED), (st == S_LOST), 17'(m_hp)};
        act_v = {bus.rise_tick, bus.fall_tick, bus.period_valid, bus.locked, bus.lost, bus.half_period};
        compared++;
        if (act_v !== exp_v) begin
          mismatched++;
          $display("FAIL cycle_model t=%0t actual rt/ft/pv/lk/lost/hp=%b%b%b%b%b/%0d required=%b%b%b%b%b/%0d",
                   $time, act_v[21], act_v[20], act_v[19], act_v[18], act_v[17], act_v[16:0],
                   exp_v[21], exp_v[20], exp_v[19], exp_v[18], exp_v[17], exp_v[16:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  bit snap_rt, snap_ft, snap_pv, snap_lk, snap_lost;
  int snap_hp;

  // Toggle, capture outputs when this edge's tick is due, next toggle gap cycles later
  task automatic step(input int gap);
    bus.slow_clk_in = ~bus.slow_clk_in;
    repeat (3) @(posedge fast_clk);
    #1;
    snap_rt = bus.rise_tick; snap_ft = bus.fall_tick; snap_pv = bus.period_valid;
    snap_lk = bus.locked; snap_lost = bus.lost; snap_hp = int'(bus.half_period);
    repeat (gap - 2) @(negedge fast_clk);
  endtask

  task automatic toggle_gap(input int gap);
    bus.slow_clk_in = ~bus.slow_clk_in;
    repeat (gap) @(negedge fast_clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks, r;
    bus.slow_clk_in = 1'b0;
    repeat (3) @(negedge fast_clk);
    chk("reset_outputs", int'({bus.rise_tick, bus.fall_tick, bus.period_valid, bus.locked,
                               bus.lost, bus.half_period}), 0);
    reset = 1'b0;
    repeat (5) @(negedge fast_clk);

    step(10); chk("e1_rise", snap_rt, 1); chk("e1_no_pv", snap_pv, 0);
    step(10); chk("e2_fall", snap_ft, 1); chk("e2_pv", snap_pv, 1); chk("e2_hp", snap_hp, 10);
    repeat (3) step(10);
    chk("e5_unlocked", snap_lk, 0);
    step(11); chk("e6_locked", snap_lk, 1);
    step(9);  chk("e7_hp", snap_hp, 11); chk("e7_locked", snap_lk, 1);
    step(11); chk("e8_hp", snap_hp, 9);  chk("e8_locked", snap_lk, 1);
    step(14); chk("e9_locked", snap_lk, 1);
    step(14); chk("e10_hp", snap_hp, 14); chk("e10_unlocked", snap_lk, 0);
    repeat (3) step(14);
    chk("e13_unlocked", snap_lk, 0);
    step(200); chk("e14_relocked", snap_lk, 1);
    chk("static_lost", bus.lost, 1); chk("static_unlocked", bus.locked, 0);
    step(20);  chk("e15_no_pv", snap_pv, 0); chk("e15_lost_clear", snap_lost, 0);
    step(101); chk("e16_pv", snap_pv, 1); chk("e16_hp", snap_hp, 20);
    step(10);  chk("e17_hp_edge_wins", snap_hp, 101); chk("e17_not_lost", snap_lost, 0);
    chk("e17_pv", snap_pv, 1);
    repeat (4) step(10);
    chk("e21_unlocked", snap_lk, 0);
    step(10);  chk("e22_locked", snap_lk, 1);

    #2;
    reset = 1'b1;
    bus.slow_clk_in = 1'b1;
    #1;
    chk("async_reset_outputs", int'({bus.rise_tick, bus.fall_tick, bus.period_valid, bus.locked,
                                     bus.lost, bus.half_period}), 0);
    repeat (3) @(negedge fast_clk);
    reset = 1'b0;
    ticks = 0;
    repeat (12) begin
      @(posedge fast_clk); #1;
      ticks += int'(bus.rise_tick);
    end
    chk("powerup_single_rise", ticks, 1);
    @(negedge fast_clk);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      toggle_gap($urandom_range(1, 3));
      else if (r == 1) toggle_gap($urandom_range(99, 103));
      else             toggle_gap($urandom_range(8, 12));
    end
    repeat (120) @(negedge fast_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
